// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 + joystick player input front end with autofire, coin stretch and SOCD
module arcade_input_mapper #(
   parameter int  PLAYERS      = 2,
   parameter int  BUTTONS      = 3,
   parameter real CLK_FREQ     = 96.0,
   parameter int  AUTOFIRE_HZ  = 10,
   parameter int  COIN_MS      = 100,
   parameter bit  SOCD_NEUTRAL = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [10:0]                  ps2_key,
   input  logic [PLAYERS*16-1:0]        joystick,
   input  logic [PLAYERS*BUTTONS-1:0]   autofire_en,
   output logic [PLAYERS*4-1:0]         joy,
   output logic [PLAYERS*BUTTONS-1:0]   buttons,
   output logic [PLAYERS-1:0]           start,
   output logic [PLAYERS-1:0]           coin,
   output logic                         pause
);

   localparam real AF_REAL     = CLK_FREQ * 1.0e6 / (2.0 * AUTOFIRE_HZ);
   localparam int  AF_CALC     = $rtoi(AF_REAL + 0.5);
   localparam int  AF_HALF     = (AF_CALC < 1) ? 1 : AF_CALC;
   localparam real COIN_REAL   = CLK_FREQ * 1000.0 * COIN_MS;
   localparam int  COIN_CALC   = $rtoi(COIN_REAL + 0.5);
   localparam int  COIN_CYCLES = (COIN_CALC < 1) ? 1 : COIN_CALC;
   localparam int  AFW         = $clog2(AF_HALF + 1);
   localparam int  CW          = $clog2(COIN_CYCLES + 1);

   // Keyboard state; only players 1 and 2 have keys. Direction nibble is {up, down, right, left}.
   logic       armed;
   logic       old_toggle;
   logic [7:0] key_dir;
   logic [5:0] key_btn;
   logic [1:0] key_start;
   logic [1:0] key_coin;
   logic       key_pause;

   logic [PLAYERS*4-1:0]       raw_dir;
   logic [PLAYERS*4-1:0]       dir_n;
   logic [PLAYERS*BUTTONS-1:0] raw_btn;
   logic [PLAYERS-1:0]         raw_start;
   logic [PLAYERS-1:0]         raw_coin;
   logic [PLAYERS-1:0]         raw_coin_q;
   logic                       raw_pause;
   logic                       raw_pause_q;
   logic [AFW-1:0]             af_cnt;
   logic                       phase;
   logic [CW-1:0]              coin_cnt [PLAYERS];

   // Key decode: ignore the toggle level seen on the first clock after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed      <= 1'b0;
         old_toggle <= 1'b0;
         key_dir    <= '0;
         key_btn    <= '0;
         key_start  <= '0;
         key_coin   <= '0;
         key_pause  <= 1'b0;
      end else begin
         old_toggle <= ps2_key[10];
         armed      <= 1'b1;
         if (armed && (ps2_key[10] != old_toggle)) begin
            case (ps2_key[7:0])
               8'h75: key_dir[3]   <= ps2_key[9];
               8'h72: key_dir[2]   <= ps2_key[9];
               8'h74: key_dir[1]   <= ps2_key[9];
               8'h6B: key_dir[0]   <= ps2_key[9];
               8'h14: key_btn[0]   <= ps2_key[9];
               8'h11: key_btn[1]   <= ps2_key[9];
               8'h29: key_btn[2]   <= ps2_key[9];
               8'h16: key_start[0] <= ps2_key[9];
               8'h2E: key_coin[0]  <= ps2_key[9];
               8'h4D: key_pause    <= ps2_key[9];
               8'h2D: key_dir[7]   <= ps2_key[9];
               8'h2B: key_dir[6]   <= ps2_key[9];
               8'h34: key_dir[5]   <= ps2_key[9];
               8'h23: key_dir[4]   <= ps2_key[9];
               8'h1C: key_btn[3]   <= ps2_key[9];
               8'h1B: key_btn[4]   <= ps2_key[9];
               8'h15: key_btn[5]   <= ps2_key[9];
               8'h1E: key_start[1] <= ps2_key[9];
               8'h36: key_coin[1]  <= ps2_key[9];
               default: ;
            endcase
         end
      end
   end

   // Raw merge of key registers and joystick bits, then opposite-direction neutralisation
   always_comb begin
      raw_dir   = '0;
      raw_btn   = '0;
      raw_start = '0;
      raw_coin  = '0;
      raw_pause = key_pause;
      for (int p = 0; p < PLAYERS; p++) begin
         raw_dir[4*p+3] = joystick[16*p+3];
         raw_dir[4*p+2] = joystick[16*p+2];
         raw_dir[4*p+1] = joystick[16*p+0];
         raw_dir[4*p+0] = joystick[16*p+1];
         for (int b = 0; b < BUTTONS; b++)
            raw_btn[BUTTONS*p+b] = joystick[16*p+4+b];
         raw_start[p] = joystick[16*p+10];
         raw_coin[p]  = joystick[16*p+11];
         raw_pause    = raw_pause | joystick[16*p+12];
         if (p < 2) begin
            raw_dir[4*p +: 4] = raw_dir[4*p +: 4] | key_dir[4*p +: 4];
            raw_start[p]      = raw_start[p] | key_start[p];
            raw_coin[p]       = raw_coin[p] | key_coin[p];
            for (int b = 0; b < BUTTONS && b < 3; b++)
               raw_btn[BUTTONS*p+b] = raw_btn[BUTTONS*p+b] | key_btn[3*p+b];
         end
      end
      dir_n = raw_dir;
      for (int p = 0; p < PLAYERS; p++) begin
         if (SOCD_NEUTRAL && raw_dir[4*p+3] && raw_dir[4*p+2]) begin
            dir_n[4*p+3] = 1'b0;
            dir_n[4*p+2] = 1'b0;
         end
         if (SOCD_NEUTRAL && raw_dir[4*p+1] && raw_dir[4*p+0]) begin
            dir_n[4*p+1] = 1'b0;
            dir_n[4*p+0] = 1'b0;
         end
      end
   end

   // Free-running autofire phase generator
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         af_cnt <= '0;
         phase  <= 1'b0;
      end else if (af_cnt == AFW'(AF_HALF - 1)) begin
         af_cnt <= '0;
         phase  <= ~phase;
      end else begin
         af_cnt <= af_cnt + 1'b1;
      end
   end

   // Registered direction, button and start outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         joy     <= '0;
         buttons <= '0;
         start   <= '0;
      end else begin
         joy     <= dir_n;
         buttons <= raw_btn & ~(autofire_en & {(PLAYERS*BUTTONS){~phase}});
         start   <= raw_start;
      end
   end

   // Coin pulse stretcher: reload on each raw rising edge, count down to zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         raw_coin_q <= '0;
         for (int p = 0; p < PLAYERS; p++)
            coin_cnt[p] <= '0;
      end else begin
         raw_coin_q <= raw_coin;
         for (int p = 0; p < PLAYERS; p++) begin
            if (raw_coin[p] && !raw_coin_q[p])
               coin_cnt[p] <= CW'(COIN_CYCLES);
            else if (coin_cnt[p] != '0)
               coin_cnt[p] <= coin_cnt[p] - 1'b1;
         end
      end
   end

   // Coin output is high while its counter is running
   always_comb begin
      coin = '0;
      for (int p = 0; p < PLAYERS; p++)
         coin[p] = (coin_cnt[p] != '0);
   end

   // Pause latch toggles on a rising edge of the combined pause request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         raw_pause_q <= 1'b0;
         pause       <= 1'b0;
      end else begin
         raw_pause_q <= raw_pause;
         if (raw_pause && !raw_pause_q)
            pause <= ~pause;
      end
   end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - directed self-checking bench for arcade_input_mapper
module tb_arcade_input_mapper;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic [31:0] joystick;
   logic [5:0]  autofire_en;
   logic [7:0]  joy;
   logic [5:0]  buttons;
   logic [1:0]  start;
   logic [1:0]  coin;
   logic        pause;

   int errors = 0;
   int checks = 0;

   arcade_input_mapper #(
      .PLAYERS(2), .BUTTONS(3), .CLK_FREQ(0.001), .AUTOFIRE_HZ(100),
      .COIN_MS(10), .SOCD_NEUTRAL(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
      .autofire_en(autofire_en), .joy(joy), .buttons(buttons),
      .start(start), .coin(coin), .pause(pause)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic key(input logic tgl, input logic pressed, input logic [7:0] code);
      ps2_key = {tgl, pressed, 1'b0, code};
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_joy"}, {24'h0, joy}, 32'h0);
      check({tag, "_btn"}, {26'h0, buttons}, 32'h0);
      check({tag, "_start"}, {30'h0, start}, 32'h0);
      check({tag, "_coin"}, {30'h0, coin}, 32'h0);
      check({tag, "_pause"}, {31'h0, pause}, 32'h0);
   endtask

   initial begin
      reset       = 1'b1;
      joystick    = '0;
      autofire_en = '0;
      key(1'b1, 1'b1, 8'h16);
      tick(3);
      check_all_zero("reset");

      // keyboard: held toggle level must not count as an event
      reset = 1'b0;
      tick(3);
      check("arm_no_event", {30'h0, start}, 32'h0);
      key(1'b0, 1'b1, 8'h16);
      tick(1);
      check("kb_start_lat1", {30'h0, start}, 32'h0);
      tick(1);
      check("kb_start_lat2", {30'h0, start}, 32'h1);
      key(1'b1, 1'b0, 8'h16);
      tick(2);
      check("kb_start_rel", {30'h0, start}, 32'h0);

      // directions and SOCD; output nibble is {up, down, right, left}
      joystick[3:0] = 4'b1000;
      tick(1);
      check("joy_up", {28'h0, joy[3:0]}, 32'h8);
      joystick[3:0] = 4'b1100;
      tick(1);
      check("socd_ud", {28'h0, joy[3:0]}, 32'h0);
      joystick[3:0] = 4'b1001;
      tick(1);
      check("joy_up_right", {28'h0, joy[3:0]}, 32'hA);
      joystick[3:0] = 4'b0011;
      tick(1);
      check("socd_lr", {28'h0, joy[3:0]}, 32'h0);
      joystick[3:0] = 4'b0010;
      tick(1);
      check("joy_left", {28'h0, joy[3:0]}, 32'h1);
      joystick[3:0]   = 4'b0000;
      joystick[19:16] = 4'b0100;
      tick(1);
      check("p2_down", {24'h0, joy}, 32'h40);
      key(1'b0, 1'b1, 8'h2D);
      tick(2);
      check("p2_kb_up_socd", {28'h0, joy[7:4]}, 32'h0);
      joystick[19:16] = 4'b0000;
      tick(1);
      check("p2_kb_up", {28'h0, joy[7:4]}, 32'h8);
      key(1'b1, 1'b0, 8'h2D);
      tick(2);
      check("p2_kb_up_rel", {24'h0, joy}, 32'h0);

      // coin stretch: held input gives one 10-clock pulse
      joystick[11] = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick(1);
         check($sformatf("coin_hold_%0d", k), {31'h0, coin[0]}, {31'h0, k <= 10});
      end
      joystick[11] = 1'b0;
      tick(15);
      // retrigger: second edge on pulse clock 6 extends to clock 15
      joystick[11] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         if (k == 5) joystick[11] = 1'b0;
         if (k == 6) joystick[11] = 1'b1;
         tick(1);
         check($sformatf("coin_retrig_%0d", k), {31'h0, coin[0]}, {31'h0, k <= 15});
      end
      joystick[11] = 1'b0;
      tick(12);
      check("coin1_idle", {31'h0, coin[1]}, 32'h0);

      // pause: simultaneous rises toggle once, key 4D toggles back
      joystick[12] = 1'b1;
      joystick[28] = 1'b1;
      tick(1);
      check("pause_both", {31'h0, pause}, 32'h1);
      tick(3);
      check("pause_hold", {31'h0, pause}, 32'h1);
      joystick[12] = 1'b0;
      joystick[28] = 1'b0;
      tick(1);
      check("pause_drop", {31'h0, pause}, 32'h1);
      key(1'b0, 1'b1, 8'h4D);
      tick(1);
      check("pause_kb_lat1", {31'h0, pause}, 32'h1);
      tick(1);
      check("pause_kb_lat2", {31'h0, pause}, 32'h0);
      key(1'b1, 1'b0, 8'h4D);
      tick(2);
      check("pause_kb_rel", {31'h0, pause}, 32'h0);

      // autofire from reset: 5 low / 5 high; button 2 without autofire stays high
      reset          = 1'b1;
      joystick       = '0;
      joystick[4]    = 1'b1;
      joystick[5]    = 1'b1;
      autofire_en    = '0;
      autofire_en[0] = 1'b1;
      tick(2);
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         check($sformatf("autofire_%0d", k), {29'h0, buttons[2:0]},
               {30'h0, 1'b1, 1'(((k - 1) / 5) % 2)});
      end
      autofire_en[0] = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         check($sformatf("af_off_%0d", k), {29'h0, buttons[2:0]}, 32'h3);
      end

      // asynchronous reset mid coin pulse with autofire running
      autofire_en[0] = 1'b1;
      joystick[3]    = 1'b1;
      joystick[10]   = 1'b1;
      joystick[11]   = 1'b1;
      joystick[12]   = 1'b1;
      tick(3);
      check("pre_rst_coin", {31'h0, coin[0]}, 32'h1);
      check("pre_rst_pause", {31'h0, pause}, 32'h1);
      check("pre_rst_joy", {28'h0, joy[3:0]}, 32'h8);
      reset = 1'b1;
      #1;
      check_all_zero("async_rst");
      joystick    = '0;
      autofire_en = '0;
      tick(2);
      reset = 1'b0;
      tick(5);
      check("post_rst_coin", {31'h0, coin[0]}, 32'h0);
      check("post_rst_pause", {31'h0, pause}, 32'h0);
      joystick[11] = 1'b1;
      tick(1);
      check("post_rst_coin_edge", {31'h0, coin[0]}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
